// File: rtl/trigger_network_monitor.sv
// Network-level supervisor for a group of per-actor trigger FSMs: launches them,
// broadcasts settled sleep/sync/waited flags, and reports network completion.
module trigger_network_monitor #(
  parameter int NUM_ACTORS    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic [NUM_ACTORS-1:0] trig_start,
  input  logic [NUM_ACTORS-1:0] trig_done,
  input  logic [NUM_ACTORS-1:0] trig_idle,
  input  logic [NUM_ACTORS-1:0] trig_sleep,
  input  logic [NUM_ACTORS-1:0] trig_sync_sleep,
  input  logic [NUM_ACTORS-1:0] trig_waited,
  output logic                  all_sleep,
  output logic                  all_sync_sleep,
  output logic                  all_waited,
  output logic [15:0]           round_count,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0]            SETTLE   = 4'(SETTLE_CYCLES);
  localparam logic [NUM_ACTORS-1:0] ALL_ONES = {NUM_ACTORS{1'b1}};

  state_t                  state;
  state_t                  state_nxt;
  logic [NUM_ACTORS-1:0]   start_pending;
  logic [NUM_ACTORS-1:0]   done_flag;
  logic [3:0]              sleep_cnt;
  logic [3:0]              sync_cnt;
  logic                    sync_prev;
  logic                    accept;

  always_comb begin
    state_nxt = state;
    ap_done   = 1'b0;
    ap_idle   = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if ((start_pending == '0) && (done_flag == ALL_ONES)) state_nxt = S_DONE;
      end
      S_DONE: begin
        ap_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ap_ready       = ap_done;
  assign trig_start     = start_pending;
  assign all_sleep      = (sleep_cnt == SETTLE);
  assign all_sync_sleep = (sync_cnt == SETTLE);
  assign state_dbg      = state;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= S_IDLE;
      start_pending <= '0;
      done_flag     <= '0;
      sleep_cnt     <= '0;
      sync_cnt      <= '0;
      sync_prev     <= 1'b0;
      all_waited    <= 1'b0;
      round_count   <= '0;
    end else begin
      state <= state_nxt;

      // A bit stays pending until its trigger is seen leaving idle.
      if (accept) start_pending <= ALL_ONES;
      else        start_pending <= start_pending & trig_idle;

      // Using the current pending value makes a same-edge clear win over done.
      if (accept)               done_flag <= '0;
      else if (state == S_RUN)  done_flag <= done_flag | (trig_done & ~start_pending);

      if ((state == S_RUN) && (&trig_sleep)) begin
        if (sleep_cnt != SETTLE) sleep_cnt <= sleep_cnt + 4'd1;
      end else begin
        sleep_cnt <= '0;
      end

      if ((state == S_RUN) && (&trig_sync_sleep)) begin
        if (sync_cnt != SETTLE) sync_cnt <= sync_cnt + 4'd1;
      end else begin
        sync_cnt <= '0;
      end

      all_waited <= (state == S_RUN) && (&trig_waited);
      sync_prev  <= all_sync_sleep;

      if (accept) round_count <= '0;
      else if (all_sync_sleep && !sync_prev && (round_count != 16'hFFFF))
        round_count <= round_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_trigger_network_monitor.sv
// Bench for trigger_network_monitor: drives a full network run with scripted
// trigger behaviour and compares against queued expectations.
module tb_trigger_network_monitor;

  localparam int N      = 4;
  localparam int SETTLE = 2;

  logic          ap_clk;
  logic          ap_rst;
  logic          ap_start;
  logic          ap_done;
  logic          ap_ready;
  logic          ap_idle;
  logic [N-1:0]  trig_start;
  logic [N-1:0]  trig_done;
  logic [N-1:0]  trig_idle;
  logic [N-1:0]  trig_sleep;
  logic [N-1:0]  trig_sync_sleep;
  logic [N-1:0]  trig_waited;
  logic          all_sleep;
  logic          all_sync_sleep;
  logic          all_waited;
  logic [15:0]   round_count;
  logic [1:0]    state_dbg;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] exp_q[$];

  trigger_network_monitor #(.NUM_ACTORS(N), .SETTLE_CYCLES(SETTLE)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
    .trig_start(trig_start), .trig_done(trig_done), .trig_idle(trig_idle),
    .trig_sleep(trig_sleep), .trig_sync_sleep(trig_sync_sleep),
    .trig_waited(trig_waited), .all_sleep(all_sleep),
    .all_sync_sleep(all_sync_sleep), .all_waited(all_waited),
    .round_count(round_count), .state_dbg(state_dbg)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (3) tick();
    ap_rst = 1'b0;
    tick();
    chk_cnt++; if (ap_idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", ap_idle); else pass_cnt++;
    chk_cnt++; if (ap_done !== 1'b0) $display("FAIL reset_done: got %b want 0", ap_done); else pass_cnt++;
    chk_cnt++; if (ap_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ap_ready); else pass_cnt++;
    chk_cnt++; if (trig_start !== 4'h0) $display("FAIL reset_trig_start: got %h want 0", trig_start); else pass_cnt++;
    chk_cnt++; if ({all_sleep, all_sync_sleep, all_waited} !== 3'b000)
      $display("FAIL reset_all_flags: got %b want 000", {all_sleep, all_sync_sleep, all_waited}); else pass_cnt++;
    chk_cnt++; if (round_count !== 16'd0) $display("FAIL reset_round_count: got %0d want 0", round_count); else pass_cnt++;
    repeat (3) tick();
    chk_cnt++; if (ap_idle !== 1'b1 || trig_start !== 4'h0)
      $display("FAIL idle_hold: got idle=%b trig_start=%h want 1/0", ap_idle, trig_start); else pass_cnt++;
  endtask

  task automatic test_run_start();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    chk_cnt++; if (trig_start !== 4'hF) $display("FAIL start_c1: got %h want f", trig_start); else pass_cnt++;
    chk_cnt++; if (ap_idle !== 1'b0) $display("FAIL start_idle: got %b want 0", ap_idle); else pass_cnt++;
    tick();
    trig_idle = 4'h0;
    chk_cnt++; if (trig_start !== 4'hF) $display("FAIL start_c2: got %h want f", trig_start); else pass_cnt++;
    tick();
    chk_cnt++; if (trig_start !== 4'h0) $display("FAIL start_c3: got %h want 0", trig_start); else pass_cnt++;
    chk_cnt++; if (ap_done !== 1'b0) $display("FAIL start_no_done: got %b want 0", ap_done); else pass_cnt++;
  endtask

  task automatic test_sleep();
    logic [11:0] pat = 12'b0001_1111_0001;
    logic [31:0] e;
    int run = 0;
    exp_q.delete();
    for (int k = 0; k <= 12; k++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if (all_sleep !== e[0]) $display("FAIL all_sleep[%0d]: got %b want %b", k, all_sleep, e[0]);
        else pass_cnt++;
      end
      if (k < 12) begin
        trig_sleep = pat[k] ? 4'hF : 4'h0;
        run = pat[k] ? run + 1 : 0;
        exp_q.push_back((run >= SETTLE) ? 32'd1 : 32'd0);
      end else begin
        trig_sleep = 4'h0;
      end
      tick();
    end
  endtask

  task automatic test_sync_sleep();
    logic [31:0] e;
    logic raw;
    int run = 0;
    exp_q.delete();
    chk_cnt++; if (round_count !== 16'd0) $display("FAIL sync_round_init: got %0d want 0", round_count); else pass_cnt++;
    for (int k = 0; k <= 26; k++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if (all_sync_sleep !== e[0]) $display("FAIL all_sync_sleep[%0d]: got %b want %b", k, all_sync_sleep, e[0]);
        else pass_cnt++;
      end
      if (k < 24) begin
        raw = ((k % 8) < 4);
        trig_sync_sleep = raw ? 4'hF : 4'h0;
        run = raw ? run + 1 : 0;
        exp_q.push_back((run >= SETTLE) ? 32'd1 : 32'd0);
      end else begin
        trig_sync_sleep = 4'h0;
      end
      tick();
    end
    chk_cnt++; if (round_count !== 16'd3) $display("FAIL sync_round_count: got %0d want 3", round_count); else pass_cnt++;
  endtask

  task automatic test_waited();
    logic [3:0] pats [5] = '{4'hF, 4'hF, 4'hF, 4'h7, 4'h0};
    logic [31:0] e;
    exp_q.delete();
    ap_start = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if (all_waited !== e[0]) $display("FAIL all_waited[%0d]: got %b want %b", k, all_waited, e[0]);
        else pass_cnt++;
      end
      if (k < 5) begin
        trig_waited = pats[k];
        exp_q.push_back((&pats[k]) ? 32'd1 : 32'd0);
      end
      tick();
    end
    ap_start = 1'b0;
    chk_cnt++; if (trig_start !== 4'h0 || ap_idle !== 1'b0)
      $display("FAIL start_ignored_in_run: got trig_start=%h idle=%b want 0/0", trig_start, ap_idle); else pass_cnt++;
  endtask

  task automatic test_completion();
    int d [4] = '{0, 3, 7, 10};
    exp_q.delete();
    for (int r = 0; r <= 15; r++) begin
      if (ap_done === 1'b1) begin
        chk_cnt++;
        if (exp_q.size() > 0 && exp_q[0] == r) begin
          pass_cnt++;
          void'(exp_q.pop_front());
          chk_cnt++; if (ap_ready !== 1'b1) $display("FAIL done_ready: got %b want 1", ap_ready); else pass_cnt++;
          chk_cnt++; if (round_count !== 16'd3) $display("FAIL done_round_count: got %0d want 3", round_count); else pass_cnt++;
        end else begin
          $display("FAIL unexpected_done: ap_done=1 at rel cycle %0d, want it only at cycle 12", r);
        end
      end
      for (int i = 0; i < N; i++) begin
        trig_done[i] = (r == d[i]);
        trig_idle[i] = (r > d[i]);
      end
      if (r == 10) exp_q.push_back(32'(r + 2));
      tick();
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL done_missing: got %0d pending ap_done want 0", exp_q.size()); else pass_cnt++;
    chk_cnt++; if (ap_idle !== 1'b1 || ap_ready !== 1'b0)
      $display("FAIL after_done: got idle=%b ready=%b want 1/0", ap_idle, ap_ready); else pass_cnt++;
    chk_cnt++; if (round_count !== 16'd3) $display("FAIL idle_round_hold: got %0d want 3", round_count); else pass_cnt++;
  endtask

  task automatic test_restart_reset();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    chk_cnt++; if (round_count !== 16'd0) $display("FAIL restart_round_clear: got %0d want 0", round_count); else pass_cnt++;
    chk_cnt++; if (trig_start !== 4'hF) $display("FAIL restart_trig_start: got %h want f", trig_start); else pass_cnt++;
    trig_idle   = 4'b1100;
    trig_sleep  = 4'hF;
    trig_waited = 4'hF;
    tick();
    chk_cnt++; if (trig_start !== 4'b1100) $display("FAIL partial_pending: got %h want c", trig_start); else pass_cnt++;
    tick();
    chk_cnt++; if (all_waited !== 1'b1) $display("FAIL pre_reset_waited: got %b want 1", all_waited); else pass_cnt++;
    tick();
    chk_cnt++; if (all_sleep !== 1'b1) $display("FAIL pre_reset_sleep: got %b want 1", all_sleep); else pass_cnt++;
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    chk_cnt++; if (ap_idle !== 1'b1) $display("FAIL midrst_idle: got %b want 1", ap_idle); else pass_cnt++;
    chk_cnt++; if (trig_start !== 4'h0) $display("FAIL midrst_trig_start: got %h want 0", trig_start); else pass_cnt++;
    chk_cnt++; if ({all_sleep, all_sync_sleep, all_waited} !== 3'b000)
      $display("FAIL midrst_all_flags: got %b want 000", {all_sleep, all_sync_sleep, all_waited}); else pass_cnt++;
    trig_idle   = 4'hF;
    trig_sleep  = 4'h0;
    trig_waited = 4'h0;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++; if (ap_done !== 1'b0) $display("FAIL midrst_no_done[%0d]: got %b want 0", k, ap_done); else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    ap_rst          = 1'b1;
    ap_start        = 1'b0;
    trig_done       = 4'h0;
    trig_idle       = 4'hF;
    trig_sleep      = 4'h0;
    trig_sync_sleep = 4'h0;
    trig_waited     = 4'h0;
    test_reset();
    test_run_start();
    test_sleep();
    test_sync_sleep();
    test_waited();
    test_completion();
    test_restart_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
